// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states: waiting, shifting bit slices, presenting the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default operand width and its bit-counter width.
    localparam int WIDTH_DEFAULT = 4;
    localparam int CW            = $clog2(WIDTH_DEFAULT);

    // Counter width for an arbitrary operand width (at least one bit).
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor slice: d = a - b - bin, with borrow-out.
module full_sub (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_d    = w_axb ^ i_bin;
    // Borrow when the minuend bit is smaller, or the bits tie and a borrow arrives.
    assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - bin, LSB first, one slice per clock,
// behind a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start begins
// an operation and is ignored while busy. done pulses for exactly one cycle
// when d/bout are updated; d/bout hold until the next completion.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = count_width(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_count;
    logic               w_diff;
    logic               w_borrow_next;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // Single reused slice operating on bit 0 of the working registers.
    full_sub u_full_sub (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_d    (w_diff),
        .o_bout (w_borrow_next)
    );

    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture, per-slice shifting, and result publication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_count  <= '0;
        end else if (r_state == ST_RUN) begin
            r_res    <= w_res_next;
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_borrow_next;
            r_count  <= r_count + CNT_W'(1);
            if (w_last) begin
                r_d    <= w_res_next;
                r_bout <= w_borrow_next;
            end
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign d         = r_d;
    assign bout      = r_bout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at WIDTH=4.
module tb_serial_sub;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic [1:0]   dbg_state;

    int total;
    int bad;

    // Scoreboard of expected {bout, d} per issued operation.
    logic [W:0] exp_q[$];
    logic [W:0] hold_val;

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .bout      (bout),
        .dbg_state (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation with a start pulse and follow it to completion.
    // wiggle: scramble start/a/b/bin during the RUN phase.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input bit wiggle);
        logic [W:0] exp;
        int         busy_cnt;
        bit         seen;
        exp = {tbin, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        exp = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        exp_q.push_back(exp);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("latency", k, W + 1);
                check("busy_cycles", busy_cnt, W);
                check("busy_in_done", busy, 0);
                exp = exp_q.pop_front();
                check("d", d, exp[W-1:0]);
                check("bout", bout, exp[W]);
                hold_val = {bout, d};
            end else begin
                if (busy) busy_cnt++;
                check("hold", {bout, d}, hold_val);
                if (wiggle && k <= 3) begin
                    start = 1'($urandom_range(0, 1));
                    a = W'($urandom_range(0, 15));
                    b = W'($urandom_range(0, 15));
                    bin = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen) check("timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int last_done;
        int done_cnt;
        total = 0;
        bad = 0;
        hold_val = '0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'd5, 4'd3, 1'b0, 1'b0);   // 2, no borrow
        run_op(4'd3, 4'd5, 1'b0, 1'b0);   // E, borrow
        run_op(4'd0, 4'd0, 1'b1, 1'b0);   // F, borrow
        run_op(4'hF, 4'hF, 1'b1, 1'b0);   // F, borrow
        run_op(4'd9, 4'd0, 1'b0, 1'b0);   // 9, F held until done
        run_op(4'd7, 4'd2, 1'b0, 1'b1);   // 5 despite input churn

        // Reset abandons an operation on its second RUN cycle.
        @(negedge clk);
        a = 4'd12; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_d", d, 0);
        check("arst_bout", bout, 0);
        @(negedge clk);
        reset = 1'b0;
        hold_val = '0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_rst", done_cnt, 0);
        run_op(4'd8, 4'd1, 1'b0, 1'b0);   // 7

        // Start held high: one result every W+1 cycles.
        @(negedge clk);
        a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
        last_done = -1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("cont_busy", busy, !done);
            if (done) begin
                done_cnt++;
                check("cont_d", d, 5);
                check("cont_bout", bout, 0);
                if (last_done >= 0) check("cont_period", k - last_done, W + 1);
                last_done = k;
            end
        end
        check("cont_count", done_cnt, 4);
        start = 1'b0;
        for (int k = 0; k < 10 && dbg_state != 2'd0; k++) @(negedge clk);
        check("final_idle", dbg_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
